// File: rtl/sid_dac_sequencer.sv
// rtl/sid_dac_sequencer.sv - dual serial DAC frame sequencer (optional macro: DAC_INVERT_EN)
module sid_dac_sequencer #(
  parameter int         CLK_DIV       = 2,
  parameter int         SAMPLE_PERIOD = 1134,
  parameter logic [3:0] CFG           = 4'b0011
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] sample_1,
  input  logic [11:0] sample_2,
  output logic        sample_req,
  output logic        busy,
  output logic        overrun,
  output logic        dac_clk,
  output logic        dac_dat_1,
  output logic        dac_dat_2,
  output logic        dac_cs_b,
  output logic        dac_le_b
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TW = $clog2(SAMPLE_PERIOD);
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(SAMPLE_PERIOD - 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_LATCH} state_t;

  state_t      state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic        tick;
  logic [PW-1:0] phase;
  logic        phase_done;
  logic        clk_low;     // within SHIFT: 0 = dac_clk high half, 1 = low half
  logic [3:0]  bit_cnt;
  logic [15:0] shreg_1, shreg_2;
  logic [11:0] data_1, data_2;

  assign tick       = enable && (tick_cnt == T_LAST);
  assign phase_done = (phase == PH_LAST);

`ifdef DAC_INVERT_EN
  assign data_1 = 12'hFFF - sample_1;
  assign data_2 = 12'hFFF - sample_2;
`else
  assign data_1 = sample_1;
  assign data_2 = sample_2;
`endif

  // Sample-rate counter: free-runs while enabled, held at zero otherwise
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                  tick_cnt <= '0;
    else if (!enable)            tick_cnt <= '0;
    else if (tick_cnt == T_LAST) tick_cnt <= '0;
    else                         tick_cnt <= tick_cnt + TW'(1);
  end

  // Sticky overrun: a tick landed while a frame was still on the wire
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                        overrun <= 1'b0;
    else if (!enable)                  overrun <= 1'b0;
    else if (tick && state != S_IDLE)  overrun <= 1'b1;
  end

  // State register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: every non-idle phase lasts CLK_DIV cycles
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (tick)                                        state_nxt = S_SETUP;
      S_SETUP: if (phase_done)                                  state_nxt = S_SHIFT;
      S_SHIFT: if (phase_done && clk_low && bit_cnt == 4'd15)   state_nxt = S_HOLD;
      S_HOLD:  if (phase_done)                                  state_nxt = S_LATCH;
      S_LATCH: if (phase_done)                                  state_nxt = S_IDLE;
      default:                                                  state_nxt = S_IDLE;
    endcase
  end

  // Phase/bit counters and shift registers; data advances only as dac_clk falls
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      phase   <= '0;
      clk_low <= 1'b0;
      bit_cnt <= '0;
      shreg_1 <= '0;
      shreg_2 <= '0;
    end else if (state == S_IDLE) begin
      phase   <= '0;
      clk_low <= 1'b0;
      bit_cnt <= '0;
      if (tick) begin
        shreg_1 <= {CFG, data_1};
        shreg_2 <= {CFG, data_2};
      end
    end else begin
      phase <= phase_done ? '0 : phase + PW'(1);
      if (state == S_SHIFT && phase_done) begin
        clk_low <= !clk_low;
        if (!clk_low) begin
          shreg_1 <= {shreg_1[14:0], 1'b0};
          shreg_2 <= {shreg_2[14:0], 1'b0};
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  // Pad and status decode; shift registers are empty by LATCH so data idles low
  always_comb begin
    busy       = (state != S_IDLE);
    sample_req = (state == S_SETUP) && (phase == '0);
    dac_cs_b   = !((state == S_SETUP) || (state == S_SHIFT));
    dac_le_b   = (state != S_LATCH);
    dac_clk    = (state == S_SHIFT) && !clk_low;
    dac_dat_1  = shreg_1[15];
    dac_dat_2  = shreg_2[15];
  end

endmodule

// File: tb/tb_sid_dac_sequencer.sv
// tb/tb_sid_dac_sequencer.sv - randomized self-checking bench for sid_dac_sequencer
module tb_sid_dac_sequencer;

  localparam int         CLK_DIV = 2;
  localparam int         SP_A    = 100;
  localparam int         SP_B    = 60;
  localparam int         FRAME   = 35 * CLK_DIV;
  localparam logic [3:0] CFG     = 4'b0011;

  logic        clk_i = 1'b0;
  logic        rst_n, enable_a, enable_b;
  logic [11:0] s1_a, s2_a, s1_b, s2_b;
  logic        req_a, busy_a, ovr_a, clk_a, dat1_a, dat2_a, cs_a, le_a;
  logic        req_b, busy_b, ovr_b, clk_b, dat1_b, dat2_b, cs_b, le_b;

  always #5 clk_i = ~clk_i;

  sid_dac_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_A), .CFG(CFG)) u_dut_a (
    .clk_i(clk_i), .rst_n(rst_n), .enable(enable_a), .sample_1(s1_a), .sample_2(s2_a),
    .sample_req(req_a), .busy(busy_a), .overrun(ovr_a), .dac_clk(clk_a),
    .dac_dat_1(dat1_a), .dac_dat_2(dat2_a), .dac_cs_b(cs_a), .dac_le_b(le_a));

  sid_dac_sequencer #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SP_B), .CFG(CFG)) u_dut_b (
    .clk_i(clk_i), .rst_n(rst_n), .enable(enable_b), .sample_1(s1_b), .sample_2(s2_b),
    .sample_req(req_b), .busy(busy_b), .overrun(ovr_b), .dac_clk(clk_b),
    .dac_dat_1(dat1_b), .dac_dat_2(dat2_b), .dac_cs_b(cs_b), .dac_le_b(le_b));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] dac_word(input logic [11:0] s);
`ifdef DAC_INVERT_EN
    return {CFG, 12'hFFF - s};
`else
    return {CFG, s};
`endif
  endfunction

  // Reference: tick on every SP-th enabled cycle; a tick starts a FRAME-long frame
  // if none is running, otherwise it is dropped and flags overrun.
  task automatic frame_model(input logic en, input int sp, inout int run, inout int remain,
                             inout logic ovr, output logic req);
    logic was_busy;
    req      = 1'b0;
    was_busy = (remain > 0);
    if (remain > 0) remain--;
    if (!en) begin
      run = 0;
      ovr = 1'b0;
    end else begin
      run++;
      if (run % sp == 0) begin
        if (was_busy) ovr = 1'b1;
        else begin
          req    = 1'b1;
          remain = FRAME;
        end
      end
    end
  endtask

  int          run_a = 0, rem_a = 0, run_b = 0, rem_b = 0;
  logic        m_ovr_a = 0, m_ovr_b = 0, m_req_a = 0, m_req_b = 0;
  logic        p_req_a = 0, p_mreq_a = 0, p_busy_a = 0, p_mbusy_a = 0, p_ovr_a = 0, p_movr_a = 0;
  logic        p_req_b = 0, p_mreq_b = 0, p_busy_b = 0, p_mbusy_b = 0, p_ovr_b = 0, p_movr_b = 0;
  logic        p_cs = 1, p_clk = 0, p_d1 = 0, p_d2 = 0;
  logic [15:0] exp1_q[$], exp2_q[$];
  logic [15:0] w1, w2;
  int          stage = 0, cs_len = 0, nbits = 0, unstable = 0, hold_len = 0, le_len = 0;
  int          stray = 0;

  // Monitor: advance the model and compare the bus one step after each rising edge
  always begin
    @(posedge clk_i);
    #1;
    if (!rst_n) begin
      run_a = 0; rem_a = 0; m_ovr_a = 0; m_req_a = 0;
      run_b = 0; rem_b = 0; m_ovr_b = 0; m_req_b = 0;
      exp1_q.delete(); exp2_q.delete();
      stage = 0;
    end else begin
      frame_model(enable_a, SP_A, run_a, rem_a, m_ovr_a, m_req_a);
      frame_model(enable_b, SP_B, run_b, rem_b, m_ovr_b, m_req_b);
      if (m_req_a) begin
        exp1_q.push_back(dac_word(s1_a));
        exp2_q.push_back(dac_word(s2_a));
      end
      if ((clk_a && rem_a == 0) || (clk_b && rem_b == 0)) stray++;

      if (stage == 0 && !cs_a && p_cs) begin
        stage = 1; cs_len = 0; nbits = 0; unstable = 0; w1 = '0; w2 = '0;
      end
      if (stage == 1) begin
        if (!cs_a) begin
          cs_len++;
          if (clk_a && !p_clk) begin
            w1 = {w1[14:0], dat1_a};
            w2 = {w2[14:0], dat2_a};
            nbits++;
          end
          if (!p_cs && (dat1_a != p_d1 || dat2_a != p_d2) && !(p_clk && !clk_a)) unstable++;
        end else begin
          if (exp1_q.size() == 0) check("frame_expected", exp1_q.size(), 1);
          else begin
            check("word_1", w1, exp1_q.pop_front());
            check("word_2", w2, exp2_q.pop_front());
          end
          check("bit_count", nbits, 16);
          check("cs_low_len", cs_len, 33 * CLK_DIV);
          check("dat_stable", unstable, 0);
          stage = 2; hold_len = 1;
        end
      end else if (stage == 2) begin
        if (!le_a) begin
          check("hold_len", hold_len, CLK_DIV);
          stage = 3; le_len = 1;
        end else hold_len++;
      end else if (stage == 3) begin
        if (le_a) begin
          check("le_low_len", le_len, CLK_DIV);
          check("dat_idle", {dat1_a, dat2_a}, 2'b00);
          stage = 0;
        end else le_len++;
      end
    end

    if (req_a != p_req_a || m_req_a != p_mreq_a) check("req_a", req_a, m_req_a);
    if (busy_a != p_busy_a || (rem_a > 0) != p_mbusy_a) check("busy_a", busy_a, rem_a > 0);
    if (ovr_a != p_ovr_a || m_ovr_a != p_movr_a) check("ovr_a", ovr_a, m_ovr_a);
    if (req_b != p_req_b || m_req_b != p_mreq_b) check("req_b", req_b, m_req_b);
    if (busy_b != p_busy_b || (rem_b > 0) != p_mbusy_b) check("busy_b", busy_b, rem_b > 0);
    if (ovr_b != p_ovr_b || m_ovr_b != p_movr_b) check("ovr_b", ovr_b, m_ovr_b);

    p_req_a = req_a; p_mreq_a = m_req_a; p_busy_a = busy_a; p_mbusy_a = (rem_a > 0);
    p_ovr_a = ovr_a; p_movr_a = m_ovr_a;
    p_req_b = req_b; p_mreq_b = m_req_b; p_busy_b = busy_b; p_mbusy_b = (rem_b > 0);
    p_ovr_b = ovr_b; p_movr_b = m_ovr_b;
    p_cs = cs_a; p_clk = clk_a; p_d1 = dat1_a; p_d2 = dat2_a;
  end

  task automatic wait_req(output int n);
    n = 0;
    do begin
      @(posedge clk_i);
      #1;
      n++;
    end while (!req_a && n < 400);
    if (!req_a) check("req_timeout", req_a, 1);
  endtask

  time t_prev;
  bit  have_prev;

  // Run frames on A: hold real samples at load, scribble mid-frame, then stage the next pair
  task automatic run_frames(input int count);
    int n;
    for (int f = 0; f < count; f++) begin
      wait_req(n);
      if (have_prev) check("period", int'(($time - t_prev) / 10), SP_A);
      t_prev = $time;
      have_prev = 1'b1;
      repeat (20) @(negedge clk_i);
      s1_a = 12'($urandom); s2_a = 12'($urandom);
      repeat (55) @(negedge clk_i);
      case (f % 3)
        0:       begin s1_a = 12'h000; s2_a = 12'hFFF; end
        1:       begin s1_a = 12'hABC; s2_a = 12'h123; end
        default: begin s1_a = 12'($urandom); s2_a = 12'($urandom); end
      endcase
      s1_b = 12'($urandom); s2_b = 12'($urandom);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; enable_a = 1'b0; enable_b = 1'b0;
    s1_a = 12'hABC; s2_a = 12'h123; s1_b = 12'h555; s2_b = 12'hAAA;
    have_prev = 1'b0;
    repeat (3) @(negedge clk_i);
    check("rst_cs_b", cs_a, 1);
    check("rst_le_b", le_a, 1);
    check("rst_clk", clk_a, 0);
    check("rst_flags", {req_a, busy_a, ovr_a, dat1_a, dat2_a}, 5'b0);

    rst_n = 1'b1;
    @(negedge clk_i);
    enable_a = 1'b1; enable_b = 1'b1;
    run_frames(6);
    check("ovr_b_set", ovr_b, 1);
    check("ovr_a_clear", ovr_a, 0);

    // Drop enable mid-shift: frame must finish, no requests while disabled
    wait_req(n);
    repeat (20) @(negedge clk_i);
    enable_a = 1'b0; enable_b = 1'b0;
    repeat (150) @(negedge clk_i);
    check("ovr_b_cleared", ovr_b, 0);
    enable_a = 1'b1; enable_b = 1'b1;
    wait_req(n);
    check("reenable_latency", n, SP_A);
    have_prev = 1'b0;

    // Asynchronous reset in the middle of a shift
    repeat (20) @(negedge clk_i);
    check("pre_rst_cs", cs_a, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_b", cs_a, 1);
    check("mid_rst_le_b", le_a, 1);
    check("mid_rst_clk", clk_a, 0);
    check("mid_rst_flags", {req_a, busy_a, ovr_a, dat1_a, dat2_a}, 5'b0);
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    wait_req(n);
    check("post_rst_latency", n, SP_A);
    t_prev = $time;
    have_prev = 1'b1;
    repeat (20) @(negedge clk_i);
    run_frames(2);

    enable_a = 1'b0; enable_b = 1'b0;
    repeat (80) @(negedge clk_i);
    check("stray_dac_clk", stray, 0);
    check("frames_pending", exp1_q.size(), 0);
    check("idle_b", {clk_b, dat1_b, dat2_b, cs_b, le_b}, 5'b00011);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
